irq_gate: RTL

- Upstream interrupt front-end for RV32core: drives the core's `interrupter` input.
- Synchronises N asynchronous external request lines and captures their rising edges as pending bits.
- Masks the pending bits, picks one winner by fixed priority, and asserts a single-level request until the core acknowledges trap entry.
- Blocks further requests until the core signals end-of-interrupt (mret retire), so there is no nesting.

---
 rtl/irq_gate_if.sv | 25 ++
 rtl/irq_gate.sv | 110 +++++++++++
 2 files changed

// File: rtl/irq_gate_if.sv
// Signal bundle between the interrupt gate and its core-side user.
// The slave modport is the gate itself; the master modport is the core/test side.
interface irq_gate_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) ();
  logic [N_SRC-1:0] src_i;
  logic [N_SRC-1:0] mask_i;
  logic             ack_i;
  logic             eoi_i;
  logic             interrupter;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending_o;
  logic             busy;

  modport master (
    output src_i, mask_i, ack_i, eoi_i,
    input  interrupter, irq_id, pending_o, busy
  );

  modport slave (
    input  src_i, mask_i, ack_i, eoi_i,
    output interrupter, irq_id, pending_o, busy
  );
endinterface

// File: rtl/irq_gate.sv
// Interrupt front-end: synchronises and edge-captures external requests, picks a
// fixed-priority winner and holds one non-nesting request until ack, then until eoi.
module irq_gate #(
  parameter int N_SRC       = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      rst,
  irq_gate_if.slave bus
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] req_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [ID_W-1:0]  winner;
  logic             interrupter_q, interrupter_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  assign rise    = s2_q & ~s3_q;
  // Masked sources keep their pending bit; the mask only gates arbitration.
  assign req_vec = pending_q & bus.mask_i;

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) winner = ID_W'(i);
    end
  end

  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    cnt_d    = cnt_q;
    clr_vec  = '0;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          irq_id_d = winner;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus.ack_i) begin
          for (int i = 0; i < N_SRC; i++) begin
            clr_vec[i] = (irq_id_q == ID_W'(i));
          end
          state_d = SERVICE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SERVICE: begin
        if (bus.eoi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge landing together with the ack clear must survive.
    pending_d     = (pending_q & ~clr_vec) | rise;
    interrupter_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      s3_q          <= '0;
      pending_q     <= '0;
      state_q       <= IDLE;
      irq_id_q      <= '0;
      cnt_q         <= '0;
      interrupter_q <= 1'b0;
    end else begin
      s1_q          <= bus.src_i;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      pending_q     <= pending_d;
      state_q       <= state_d;
      irq_id_q      <= irq_id_d;
      cnt_q         <= cnt_d;
      interrupter_q <= interrupter_d;
    end
  end

  assign bus.interrupter = interrupter_q;
  assign bus.irq_id      = irq_id_q;
  assign bus.pending_o   = pending_q;
  assign bus.busy        = (state_q == REQ) || (state_q == SERVICE);

endmodule
